flash_responder: RTL and testbench



---
 rtl/flash_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_flash_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_responder.sv
// flash_responder: SPI NOR-flash device model sampled in the clk domain.
// Serves a byte array with WREN/WRDI/RDSR/RDID/READ/PP/SE and a WIP interval.
module flash_responder #(
  parameter int          ADDR_BITS   = 16,
  parameter int          PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
  input  logic clk,
  input  logic reset,
  input  logic flashClk,
  input  logic flashMosi,
  input  logic flashCs,
  output logic flashMiso,
  output logic busy,
  output logic wel
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SB    = ADDR_BITS - 12;

  localparam logic [7:0] C_WREN = 8'h06;
  localparam logic [7:0] C_WRDI = 8'h04;
  localparam logic [7:0] C_RDSR = 8'h05;
  localparam logic [7:0] C_RDID = 8'h9F;
  localparam logic [7:0] C_READ = 8'h03;
  localparam logic [7:0] C_PP   = 8'h02;
  localparam logic [7:0] C_SE   = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ,
    S_PROG, S_STATUS, S_ID, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ, OP_PROG, OP_ERASE
  } op_t;

  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  logic [2:0]           sck_sy;
  logic [2:0]           cs_sy;
  logic [1:0]           mosi_sy;
  state_t               state;
  op_t                  op;
  logic [2:0]           bit_cnt;
  logic [6:0]           shift_in;
  logic [7:0]           shift_out;
  logic                 miso_q;
  logic [ADDR_BITS-1:0] addr;
  logic [1:0]           abyte;
  logic [1:0]           id_idx;
  logic                 prog_en;
  logic                 prog_wr;
  logic                 erase_arm;
  logic                 erasing;
  logic                 fetch;
  logic                 wip;
  logic [11:0]          cnt;
  logic [SB-1:0]        sector;

  logic                 sck_rise;
  logic                 sck_fall;
  logic                 cs_rise;
  logic                 cs_fall;
  logic                 active;
  logic                 done;
  logic [7:0]           byte_next;
  logic [11:0]          lim;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [7:0]           wdata;

  assign sck_rise  = sck_sy[1] & ~sck_sy[2];
  assign sck_fall  = ~sck_sy[1] & sck_sy[2];
  assign cs_rise   = cs_sy[1] & ~cs_sy[2];
  assign cs_fall   = ~cs_sy[1] & cs_sy[2];
  assign active    = ~cs_sy[1] & ~cs_sy[2];
  assign done      = active & sck_rise & (bit_cnt == 3'd7);
  assign byte_next = {shift_in, mosi_sy[1]};
  assign lim       = erasing ? 12'hFFF : 12'(PROG_CYCLES - 1);

  assign flashMiso = miso_q & ~flashCs;
  assign busy      = wip;

  // Erase engine owns the write port; SPI programs only run when idle.
  always_comb begin
    we    = 1'b0;
    waddr = addr;
    wdata = mem[addr] & byte_next;
    if (erasing) begin
      we    = 1'b1;
      waddr = {sector, cnt};
      wdata = 8'hFF;
    end else if (state == S_PROG && done) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sy    <= '0;
      cs_sy     <= '1;
      mosi_sy   <= '0;
      state     <= S_IDLE;
      op        <= OP_READ;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      miso_q    <= 1'b0;
      addr      <= '0;
      abyte     <= '0;
      id_idx    <= '0;
      prog_en   <= 1'b0;
      prog_wr   <= 1'b0;
      erase_arm <= 1'b0;
      erasing   <= 1'b0;
      fetch     <= 1'b0;
      wip       <= 1'b0;
      wel       <= 1'b0;
      cnt       <= '0;
      sector    <= '0;
    end else begin
      sck_sy  <= {sck_sy[1:0], flashClk};
      cs_sy   <= {cs_sy[1:0], flashCs};
      mosi_sy <= {mosi_sy[0], flashMosi};
      fetch   <= 1'b0;

      if (fetch) begin
        shift_out <= mem[addr];
        addr      <= addr + ADDR_BITS'(1);
      end

      if (wip) begin
        if (cnt == lim) begin
          wip     <= 1'b0;
          erasing <= 1'b0;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 12'd1;
        end
      end

      if (cs_rise) begin
        state     <= S_IDLE;
        bit_cnt   <= '0;
        miso_q    <= 1'b0;
        shift_out <= '0;
        prog_wr   <= 1'b0;
        erase_arm <= 1'b0;
        if (state == S_PROG && prog_wr) begin
          wel <= 1'b0;
          wip <= 1'b1;
          cnt <= '0;
        end else if (erase_arm && wel) begin
          wel     <= 1'b0;
          wip     <= 1'b1;
          erasing <= 1'b1;
          cnt     <= '0;
          sector  <= addr[ADDR_BITS-1:12];
        end
      end else if (cs_fall) begin
        if (state == S_IDLE) begin
          state     <= S_CMD;
          bit_cnt   <= '0;
          shift_in  <= '0;
          shift_out <= '0;
          miso_q    <= 1'b0;
        end
      end else if (active) begin
        if (sck_fall) begin
          miso_q    <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
        if (sck_rise) begin
          shift_in <= byte_next[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (done) begin
          unique case (state)
            S_CMD: begin
              if (wip && byte_next != C_RDSR) begin
                state <= S_IGNORE;
              end else begin
                unique case (byte_next)
                  C_WREN: begin
                    wel   <= 1'b1;
                    state <= S_IGNORE;
                  end
                  C_WRDI: begin
                    wel   <= 1'b0;
                    state <= S_IGNORE;
                  end
                  C_RDSR: begin
                    shift_out <= {6'b0, wel, wip};
                    state     <= S_STATUS;
                  end
                  C_RDID: begin
                    shift_out <= JEDEC_ID[23:16];
                    id_idx    <= 2'd1;
                    state     <= S_ID;
                  end
                  C_READ: begin
                    op    <= OP_READ;
                    abyte <= '0;
                    state <= S_ADDR;
                  end
                  C_PP: begin
                    op      <= OP_PROG;
                    prog_en <= wel;
                    abyte   <= '0;
                    state   <= S_ADDR;
                  end
                  C_SE: begin
                    op    <= OP_ERASE;
                    abyte <= '0;
                    state <= S_ADDR;
                  end
                  default: state <= S_IGNORE;
                endcase
              end
            end
            S_ADDR: begin
              addr  <= {addr[ADDR_BITS-9:0], byte_next};
              abyte <= abyte + 2'd1;
              if (abyte == 2'd2) begin
                unique case (op)
                  OP_READ: begin
                    fetch <= 1'b1;
                    state <= S_READ;
                  end
                  OP_PROG: state <= prog_en ? S_PROG : S_IGNORE;
                  default: begin
                    erase_arm <= 1'b1;
                    state     <= S_IGNORE;
                  end
                endcase
              end
            end
            S_READ: fetch <= 1'b1;
            S_PROG: begin
              addr[7:0] <= addr[7:0] + 8'd1;
              prog_wr   <= 1'b1;
            end
            S_STATUS: shift_out <= {6'b0, wel, wip};
            S_ID: begin
              unique case (id_idx)
                2'd1:    shift_out <= JEDEC_ID[15:8];
                2'd2:    shift_out <= JEDEC_ID[7:0];
                default: shift_out <= 8'h00;
              endcase
              if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: SPI master driving flash_responder, checked against
// a byte-array flash model kept in the bench.
module tb_flash_responder;
  localparam int HALF = 6;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flashClk = 1'b0;
  logic flashMosi = 1'b0;
  logic flashCs = 1'b1;
  logic flashMiso;
  logic busy;
  logic wel;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_mem [65536];
  logic       m_wel = 1'b0;
  logic       m_busy = 1'b0;

  flash_responder dut (
    .clk      (clk),
    .reset    (reset),
    .flashClk (flashClk),
    .flashMosi(flashMosi),
    .flashCs  (flashCs),
    .flashMiso(flashMiso),
    .busy     (busy),
    .wel      (wel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // nbits == 0 clocks every bit of tx; otherwise stops after nbits.
  task automatic xact(input bq_t tx, input int nbits, output bq_t r);
    logic [7:0] b;
    int sent;
    r = {};
    sent = 0;
    b = '0;
    repeat (8) @(negedge clk);
    flashCs = 1'b0;
    repeat (HALF) @(negedge clk);
    foreach (tx[k]) begin
      for (int i = 7; i >= 0; i--) begin
        if (nbits == 0 || sent < nbits) begin
          flashMosi = tx[k][i];
          repeat (HALF) @(negedge clk);
          b[i] = flashMiso;
          flashClk = 1'b1;
          repeat (HALF) @(negedge clk);
          flashClk = 1'b0;
          sent++;
        end
      end
      r.push_back(b);
    end
    repeat (HALF) @(negedge clk);
    flashCs = 1'b1;
  endtask

  task automatic send(input bq_t tx, output bq_t r);
    xact(tx, 0, r);
  endtask

  function automatic void m_pp(input logic [23:0] a, input bq_t d);
    logic [15:0] x;
    if (!m_wel || d.size() == 0) return;
    foreach (d[i]) begin
      x = {a[15:8], 8'(a[7:0] + 8'(i))};
      ref_mem[x] = ref_mem[x] & d[i];
    end
    m_wel = 1'b0;
  endfunction

  function automatic void m_se(input logic [23:0] a);
    if (!m_wel) return;
    for (int i = 0; i < 4096; i++) ref_mem[{a[15:12], 12'(i)}] = 8'hFF;
    m_wel = 1'b0;
  endfunction

  task automatic wren();
    bq_t t, r;
    t = {8'h06};
    send(t, r);
    if (!m_busy) m_wel = 1'b1;
  endtask

  task automatic wrdi();
    bq_t t, r;
    t = {8'h04};
    send(t, r);
    if (!m_busy) m_wel = 1'b0;
  endtask

  task automatic pp(input logic [23:0] a, input bq_t d);
    bq_t t, r;
    t = {8'h02, a[23:16], a[15:8], a[7:0]};
    foreach (d[i]) t.push_back(d[i]);
    send(t, r);
    m_pp(a, d);
  endtask

  task automatic se(input logic [23:0] a);
    bq_t t, r;
    t = {8'h20, a[23:16], a[15:8], a[7:0]};
    send(t, r);
  endtask

  task automatic rd_chk(input logic [23:0] a, input int n, input string tag);
    bq_t t, r;
    t = {8'h03, a[23:16], a[15:8], a[7:0]};
    repeat (n) t.push_back(8'h00);
    send(t, r);
    for (int i = 0; i < n; i++)
      chk(tag, r[4+i], ref_mem[16'(a[15:0] + 16'(i))]);
  endtask

  task automatic status_chk(input string tag);
    bq_t t, r;
    logic [7:0] exp;
    t = {8'h05, 8'h00, 8'h00};
    send(t, r);
    exp = {6'b0, m_wel, m_busy};
    chk(tag, r[1], exp);
    chk(tag, r[2], exp);
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag);
    int w;
    w = 0;
    while (busy !== lvl && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk(tag, busy, lvl);
  endtask

  task automatic busy_len(input int exp, input string tag);
    int n;
    int w;
    w = 0;
    while (busy !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t t, r, d, idq;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'hFF;

    #23;
    chk("rst_busy", busy, 0);
    chk("rst_wel", wel, 0);
    chk("rst_miso", flashMiso, 0);
    reset = 1'b1;

    wren();
    chk("wel_set", wel, m_wel);
    status_chk("rdsr_wren");
    wrdi();
    status_chk("rdsr_wrdi");
    chk("wel_clr", wel, m_wel);

    t = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
    send(t, r);
    idq = {8'hEF, 8'h40, 8'h16, 8'h00};
    for (int i = 0; i < 4; i++) chk("jedec", r[1+i], idq[i]);

    wren();
    d = {8'h5A, 8'hA5, 8'h3C};
    pp(24'h0000FE, d);
    busy_len(64, "pp_busy");
    status_chk("rdsr_pp");
    chk("wel_pp", wel, m_wel);
    rd_chk(24'h0000FE, 2, "rd_fe");
    rd_chk(24'h000000, 1, "rd_page_wrap");

    wren();
    d = {8'h0F};
    pp(24'h0000FE, d);
    busy_len(64, "pp_and_busy");
    rd_chk(24'h0000FE, 1, "rd_and");
    d = {8'h00};
    pp(24'h000010, d);
    repeat (40) @(negedge clk);
    chk("nowel_busy", busy, 0);
    rd_chk(24'h000010, 1, "rd_nowel");

    for (int it = 0; it < 5; it++) begin
      logic [23:0] a;
      int len;
      a = {8'($urandom), 16'($urandom_range(16'h2000, 16'hEFFF))};
      len = $urandom_range(1, 4);
      d = {};
      for (int j = 0; j < len; j++) d.push_back(8'($urandom));
      wren();
      pp(a, d);
      busy_len(64, "rnd_busy");
      rd_chk(a, 4, "rnd_rd");
    end

    wren();
    d = {8'h81};
    pp(24'h001234, d);
    busy_len(64, "pp_sec");
    wren();
    d = {8'h77};
    pp(24'h000FFF, d);
    busy_len(64, "pp_fff");
    rd_chk(24'h001234, 1, "rd_pre_se");
    wren();
    se(24'h001234);
    busy_len(4096, "se_busy");
    m_se(24'h001234);
    status_chk("rdsr_se");
    rd_chk(24'h001000, 4, "rd_se_lo");
    rd_chk(24'h001232, 4, "rd_se_mid");
    rd_chk(24'h001FFC, 4, "rd_se_hi");
    rd_chk(24'h000FFD, 3, "rd_se_below");

    wren();
    d = {8'h44};
    pp(24'h001100, d);
    busy_len(64, "pp_1100");
    wren();
    se(24'h001100);
    m_se(24'h001100);
    wait_busy(1'b1, 50, "se2_start");
    m_busy = 1'b1;
    t = {8'h03, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00};
    send(t, r);
    chk("rd_busy0", r[4], 0);
    chk("rd_busy1", r[5], 0);
    status_chk("rdsr_busy");
    wait_busy(1'b0, 5000, "se2_end");
    m_busy = 1'b0;
    rd_chk(24'h001100, 1, "rd_se2");

    wren();
    d = {8'h12};
    pp(24'h001500, d);
    busy_len(64, "pp_1500");
    wren();
    t = {8'h20, 8'h00, 8'h15, 8'h00};
    xact(t, 20, r);
    repeat (30) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_wel", wel, m_wel);
    rd_chk(24'h001500, 1, "rd_abort");

    se(24'h001500);
    wait_busy(1'b1, 50, "se3_start");
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_miso", flashMiso, 0);
    chk("rst_mid_wel", wel, 0);
    m_wel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    status_chk("rdsr_post_rst");
    rd_chk(24'h001500, 1, "rd_post_rst");

    rd_chk(24'h00FFFF, 2, "rd_top_wrap");
    rd_chk(24'hAB00FE, 1, "rd_alias");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
